// File: rtl/rs_syndrome_calc.sv
// rs_syndrome_calc: syndrome calculator for the RS(31,k) decoder over GF(2^5).
// It takes received symbols highest degree first and evaluates r(alpha^(FCR+k))
// for TWO_T roots in parallel, using Horner's rule.
module rs_syndrome_calc #(
   parameter int N     = 31,
   parameter int TWO_T = 8,
   parameter int FCR   = 1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 in_valid,
   input  logic                 in_sop,
   input  logic [4:0]           in_sym,
   output logic                 syn_valid,
   output logic [5*TWO_T-1:0]   syn_out,
   output logic                 syn_nonzero,
   output logic                 busy
);

   typedef enum logic {IDLE, ACCUM} state_t;

   localparam logic [4:0] LAST_CNT = 5'(N - 1);

   // GF(2^5) multiply, reduced by x^5+x^2+1; bit 0 is the x^0 coefficient.
   function automatic logic [4:0] lcpmult(input logic [4:0] a, input logic [4:0] b);
      logic [4:0] prod;
      logic [4:0] shifted;
      prod    = '0;
      shifted = a;
      for (int i = 0; i < 5; i++) begin
         if (b[i]) prod = prod ^ shifted;
         shifted = {shifted[3:0], 1'b0} ^ (shifted[4] ? 5'b00101 : 5'b00000);
      end
      return prod;
   endfunction

   // GF addition is a carry-free XOR.
   function automatic logic [4:0] gfadder(input logic [4:0] a, input logic [4:0] b);
      return a ^ b;
   endfunction

   // alpha^e, evaluated once at elaboration to give each syndrome its constant root.
   function automatic logic [4:0] alpha_pow(input int e);
      logic [4:0] r;
      r = 5'b00001;
      for (int i = 0; i < 31; i++) begin
         if (i < e) r = lcpmult(r, 5'b00010);
      end
      return r;
   endfunction

   state_t               state;
   state_t               next_state;
   logic [4:0]           count;
   logic [5*TWO_T-1:0]   acc;
   logic [5*TWO_T-1:0]   horner;
   logic                 start;
   logic                 step;
   logic                 last;

   // One Horner step per syndrome: acc_k * alpha^(FCR+k) + incoming symbol.
   for (genvar k = 0; k < TWO_T; k++) begin : g_syn
      localparam logic [4:0] ROOT = alpha_pow((FCR + k) % 31);
      assign horner[5*k +: 5] = gfadder(lcpmult(acc[5*k +: 5], ROOT), in_sym);
   end

   assign busy = (state == ACCUM);

   // Decode the input events, then choose the next FSM state.
   always_comb begin
      start      = in_valid && in_sop;
      step       = (state == ACCUM) && in_valid && !in_sop;
      last       = step && (count == LAST_CNT);
      next_state = state;
      case (state)
         IDLE: begin
            if (start && (N > 1)) next_state = ACCUM;
         end
         ACCUM: begin
            if (start)     next_state = (N > 1) ? ACCUM : IDLE;
            else if (last) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   // Accumulators, symbol counter and the held syndrome outputs.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         acc         <= '0;
         count       <= '0;
         syn_valid   <= 1'b0;
         syn_out     <= '0;
         syn_nonzero <= 1'b0;
      end else begin
         syn_valid <= 1'b0;
         if (start) begin
            acc <= {TWO_T{in_sym}};
            if (N == 1) begin
               syn_out     <= {TWO_T{in_sym}};
               syn_nonzero <= |in_sym;
               syn_valid   <= 1'b1;
               count       <= '0;
            end else begin
               count <= 5'd1;
            end
         end else if (last) begin
            syn_out     <= horner;
            syn_nonzero <= |horner;
            syn_valid   <= 1'b1;
            count       <= '0;
         end else if (step) begin
            acc   <= horner;
            count <= count + 5'd1;
         end
      end
   end

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Testbench for rs_syndrome_calc.
// A log/antilog model evaluates each syndrome as a sum of r_i * alpha^(j*deg_i),
// and the DUT outputs are compared against that model on every cycle.
module tb_rs_syndrome_calc;

   localparam int N     = 31;
   localparam int TWO_T = 8;
   localparam int FCR   = 1;
   localparam int W     = 5 * TWO_T;

   localparam logic [W-1:0] ALL_ONES = {TWO_T{5'd1}};
   localparam logic [W-1:0] DEG1_SYN = {5'd13, 5'd20, 5'd10, 5'd5, 5'd16, 5'd8, 5'd4, 5'd2};

   logic          clock    = 1'b0;
   logic          reset_n  = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_sop   = 1'b0;
   logic [4:0]    in_sym   = 5'd0;
   logic          syn_valid;
   logic [W-1:0]  syn_out;
   logic          syn_nonzero;
   logic          busy;

   rs_syndrome_calc #(.N(N), .TWO_T(TWO_T), .FCR(FCR)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_sop      (in_sop),
      .in_sym      (in_sym),
      .syn_valid   (syn_valid),
      .syn_out     (syn_out),
      .syn_nonzero (syn_nonzero),
      .busy        (busy)
   );

   // 10 ns clock period.
   always #5 clock = ~clock;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   int exp_tab[31];
   int log_tab[32];

   int           blk[$];
   bit           in_blk    = 1'b0;
   logic         exp_valid = 1'b0;
   logic [W-1:0] exp_syn   = '0;
   logic         exp_nz    = 1'b0;
   logic         exp_busy  = 1'b0;

   int           strobes     = 0;
   int           last_strobe = 0;
   int           prev_strobe = 0;
   logic [W-1:0] captured[$];
   int           sop_cyc     = 0;
   logic [4:0]   cw[N];

   // Build the GF(2^5) antilog/log tables from x^5 = x^2 + 1.
   initial begin
      int v;
      v = 1;
      for (int i = 0; i < 31; i++) begin
         exp_tab[i] = v;
         log_tab[v] = i;
         v = v << 1;
         if ((v & 32) != 0) v = v ^ 37;
      end
   end

   function automatic int gmul(input int a, input int b);
      if (a == 0 || b == 0) return 0;
      return exp_tab[(log_tab[a] + log_tab[b]) % 31];
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
      end
   endtask

   // Reference model: collects a codeword's symbols and evaluates every syndrome once N have arrived.
   always @(posedge clock) begin
      cyc++;
      exp_valid = 1'b0;
      if (!reset_n) begin
         blk.delete();
         in_blk  = 1'b0;
         exp_syn = '0;
         exp_nz  = 1'b0;
      end else if (in_valid) begin
         if (in_sop) begin
            blk.delete();
            blk.push_back(int'(in_sym));
            in_blk = 1'b1;
         end else if (in_blk) begin
            blk.push_back(int'(in_sym));
         end
         if (in_blk && blk.size() == N) begin
            for (int k = 0; k < TWO_T; k++) begin
               int s;
               s = 0;
               for (int i = 0; i < N; i++)
                  s = s ^ gmul(blk[i], exp_tab[((FCR + k) * (N - 1 - i)) % 31]);
               exp_syn[5*k +: 5] = 5'(s);
            end
            exp_nz    = (exp_syn != '0);
            exp_valid = 1'b1;
            in_blk    = 1'b0;
            blk.delete();
         end
      end
      exp_busy = in_blk;
   end

   // Compare every DUT output against the model on each falling edge.
   always @(negedge clock) begin
      if (cyc > 0) begin
         checkOutput("syn_valid", 64'(syn_valid), 64'(exp_valid));
         checkOutput("busy", 64'(busy), 64'(exp_busy));
         checkOutput("syn_out", 64'(syn_out), 64'(exp_syn));
         checkOutput("syn_nonzero", 64'(syn_nonzero), 64'(exp_nz));
         if (syn_valid === 1'b1) begin
            strobes++;
            prev_strobe = last_strobe;
            last_strobe = cyc;
            captured.push_back(syn_out);
         end
      end
   end

   task automatic applyStimulus(input logic v, input logic s, input logic [4:0] sym);
      in_valid = v;
      in_sop   = s;
      in_sym   = sym;
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 5'd0);
   endtask

   task automatic setCodeword(input int err_deg, input logic [4:0] err_val);
      for (int i = 0; i < N; i++) cw[i] = 5'd0;
      if (err_deg >= 0) cw[N-1-err_deg] = err_val;
   endtask

   // Send the first n symbols of cw, inserting an idle cycle ahead of symbol index a, b or c.
   task automatic sendCodeword(input int n, input int a, input int b, input int c);
      for (int i = 0; i < n; i++) begin
         if (i == a || i == b || i == c) applyStimulus(1'b0, 1'b0, 5'h1f);
         applyStimulus(1'b1, (i == 0), cw[i]);
         if (i == 0) sop_cyc = cyc;
      end
   endtask

   initial begin
      int base;
      int sa;
      int sb;
      int sc;

      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      idle(2);

      $display("[TB] all-zero codeword");
      base = strobes;
      setCodeword(-1, 5'd0);
      sendCodeword(N, -1, -1, -1);
      idle(3);
      checkOutput("zero_strobes", 64'(strobes - base), 64'd1);
      checkOutput("zero_latency", 64'(last_strobe - sop_cyc), 64'd30);
      checkOutput("zero_syn", 64'(captured[$]), 64'd0);

      $display("[TB] degree-0 error, with stray symbols before sop");
      applyStimulus(1'b1, 1'b0, 5'h1f);
      applyStimulus(1'b1, 1'b0, 5'h0a);
      base = strobes;
      setCodeword(0, 5'd1);
      sendCodeword(N, -1, -1, -1);
      idle(3);
      checkOutput("deg0_strobes", 64'(strobes - base), 64'd1);
      checkOutput("deg0_syn", 64'(captured[$]), 64'(ALL_ONES));
      checkOutput("deg0_nonzero", 64'(syn_nonzero), 64'd1);

      $display("[TB] degree-1 error");
      base = strobes;
      setCodeword(1, 5'd1);
      sendCodeword(N, -1, -1, -1);
      idle(3);
      checkOutput("deg1_strobes", 64'(strobes - base), 64'd1);
      checkOutput("deg1_syn", 64'(captured[$]), 64'(DEG1_SYN));
      checkOutput("deg1_latency", 64'(last_strobe - sop_cyc), 64'd30);

      $display("[TB] degree-1 error with three stall cycles");
      sa = $urandom_range(1, 10);
      sb = $urandom_range(11, 20);
      sc = $urandom_range(21, 30);
      base = strobes;
      sendCodeword(N, sa, sb, sc);
      idle(3);
      checkOutput("stall_strobes", 64'(strobes - base), 64'd1);
      checkOutput("stall_syn", 64'(captured[$]), 64'(DEG1_SYN));
      checkOutput("stall_latency", 64'(last_strobe - sop_cyc), 64'd33);

      $display("[TB] back-to-back codewords");
      base = strobes;
      setCodeword(0, 5'd1);
      sendCodeword(N, -1, -1, -1);
      setCodeword(-1, 5'd0);
      sendCodeword(N, -1, -1, -1);
      idle(3);
      checkOutput("b2b_strobes", 64'(strobes - base), 64'd2);
      checkOutput("b2b_gap", 64'(last_strobe - prev_strobe), 64'd31);
      checkOutput("b2b_first_syn", 64'(captured[captured.size()-2]), 64'(ALL_ONES));
      checkOutput("b2b_second_syn", 64'(captured[$]), 64'd0);

      $display("[TB] abort by sop at symbol 10");
      base = strobes;
      setCodeword(1, 5'd1);
      sendCodeword(10, -1, -1, -1);
      setCodeword(0, 5'd1);
      sendCodeword(N, -1, -1, -1);
      idle(3);
      checkOutput("abort_strobes", 64'(strobes - base), 64'd1);
      checkOutput("abort_syn", 64'(captured[$]), 64'(ALL_ONES));
      checkOutput("abort_latency", 64'(last_strobe - sop_cyc), 64'd30);

      $display("[TB] reset at symbol 20");
      base = strobes;
      setCodeword(1, 5'd1);
      sendCodeword(20, -1, -1, -1);
      reset_n = 1'b0;
      applyStimulus(1'b1, 1'b0, 5'd3);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_syn", 64'(syn_out), 64'd0);
      checkOutput("reset_nonzero", 64'(syn_nonzero), 64'd0);
      reset_n = 1'b1;
      idle(40);
      checkOutput("reset_no_strobe", 64'(strobes - base), 64'd0);

      $display("[TB] recovery after reset");
      base = strobes;
      sendCodeword(N, -1, -1, -1);
      idle(3);
      checkOutput("recover_strobes", 64'(strobes - base), 64'd1);
      checkOutput("recover_syn", 64'(captured[$]), 64'(DEG1_SYN));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
